// File: rtl/fp_mul_round_pack.sv
// FP multiply back end: normalizes the raw significand product, rounds to
// nearest-even, resolves exception classes and packs a single or half result.
module fp_mul_round_pack #(
  parameter int PIPE_STAGES  = 3,
  parameter int FLUSH_DENORM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] MANT,
  input  logic [8:0]  EXP,
  input  logic        SIGN,
  input  logic [4:0]  FLAGS,
  input  logic        MODE_FP,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  out_flags
);

  localparam logic FTZ = (FLUSH_DENORM != 0);

  typedef enum logic [2:0] {K_NORM, K_INF, K_NAN, K_OVF, K_UNF} kind_e;

  typedef struct packed {
    logic [47:0] mant;
    logic [8:0]  exp;
    logic        sign;
    logic [4:0]  flags;
    logic        mode;
  } req_t;

  typedef struct packed {
    kind_e       kind;
    logic        sign;
    logic        mode;
    logic [9:0]  e;
    logic [22:0] frac;
    logic        g;
    logic        s;
  } norm_t;

  typedef struct packed {
    kind_e       kind;
    logic        sign;
    logic        mode;
    logic [9:0]  e;
    logic [22:0] frac;
    logic        inexact;
  } rnd_t;

  // vld_pipe[0]: captured request, [1]: normalized, [2]: rounded, [3]: output
  logic [PIPE_STAGES:0] vld_pipe_q, vld_pipe_d;
  req_t                 req_q, req_d;
  norm_t                norm_q, norm_d;
  rnd_t                 rnd_q, rnd_d;
  logic [31:0]          result_q, result_d;
  logic [3:0]           out_flags_q, out_flags_d;
  logic                 stall;

  assign stall     = vld_pipe_q[PIPE_STAGES] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe_q[PIPE_STAGES];
  assign result    = result_q;
  assign out_flags = out_flags_q;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    req_d      = req_q;
    if (!stall) begin
      vld_pipe_d = {vld_pipe_q[PIPE_STAGES-1:0], in_valid};
      req_d      = '{mant: MANT, exp: EXP, sign: SIGN, flags: FLAGS, mode: MODE_FP};
    end
  end

  // Stage 1: class decode and normalization
  always_comb begin
    norm_d = norm_q;
    if (!stall) begin
      norm_d.sign = req_q.sign;
      norm_d.mode = req_q.mode;
      norm_d.e    = {1'b0, req_q.exp} + {9'd0, req_q.mant[47]};
      if (req_q.flags == 5'b11111)                              norm_d.kind = K_INF;
      else if (req_q.flags == 5'b00001)                         norm_d.kind = K_NAN;
      else if (req_q.flags == 5'b00010)                         norm_d.kind = K_OVF;
      else if (req_q.flags == 5'b00011 || req_q.flags == 5'b10000) norm_d.kind = K_UNF;
      else if (req_q.flags == 5'b00000)                         norm_d.kind = K_NORM;
      else                                                      norm_d.kind = K_NAN;
      if (req_q.mode) begin
        if (req_q.mant[47]) begin
          norm_d.frac = req_q.mant[46:24];
          norm_d.g    = req_q.mant[23];
          norm_d.s    = |req_q.mant[22:0];
        end else begin
          norm_d.frac = req_q.mant[45:23];
          norm_d.g    = req_q.mant[22];
          norm_d.s    = |req_q.mant[21:0];
        end
      end else begin
        if (req_q.mant[47]) begin
          norm_d.frac = {13'd0, req_q.mant[46:37]};
          norm_d.g    = req_q.mant[36];
          norm_d.s    = |req_q.mant[35:0];
        end else begin
          norm_d.frac = {13'd0, req_q.mant[45:36]};
          norm_d.g    = req_q.mant[35];
          norm_d.s    = |req_q.mant[34:0];
        end
      end
    end
  end

  // Stage 2: round to nearest-even; a carry-out leaves the fraction at zero
  logic        rnd_up, rnd_carry;
  logic [23:0] sum_s;
  logic [10:0] sum_h;

  always_comb begin
    rnd_up    = norm_q.g & (norm_q.s | norm_q.frac[0]);
    sum_s     = {1'b0, norm_q.frac} + {23'd0, rnd_up};
    sum_h     = {1'b0, norm_q.frac[9:0]} + {10'd0, rnd_up};
    rnd_carry = norm_q.mode ? sum_s[23] : sum_h[10];
    rnd_d     = rnd_q;
    if (!stall) begin
      rnd_d.kind    = norm_q.kind;
      rnd_d.sign    = norm_q.sign;
      rnd_d.mode    = norm_q.mode;
      rnd_d.frac    = norm_q.mode ? sum_s[22:0] : {13'd0, sum_h[9:0]};
      rnd_d.e       = norm_q.e + {9'd0, rnd_carry};
      rnd_d.inexact = norm_q.g | norm_q.s;
    end
  end

  // Stage 3: exponent range check and packing
  logic [9:0]  emax;
  logic [31:0] inf_v, zero_v, nan_v, norm_v, pack_v;
  logic [3:0]  pack_f;

  always_comb begin
    emax   = rnd_q.mode ? 10'd255 : 10'd31;
    inf_v  = rnd_q.mode ? {rnd_q.sign, 8'hFF, 23'd0} : {16'd0, rnd_q.sign, 5'h1F, 10'd0};
    zero_v = rnd_q.mode ? {rnd_q.sign, 31'd0} : {16'd0, rnd_q.sign, 15'd0};
    nan_v  = rnd_q.mode ? 32'h7FC0_0000 : 32'h0000_7E00;
    norm_v = rnd_q.mode ? {rnd_q.sign, rnd_q.e[7:0], rnd_q.frac}
                        : {16'd0, rnd_q.sign, rnd_q.e[4:0], rnd_q.frac[9:0]};
    pack_v = '0;
    pack_f = '0;
    case (rnd_q.kind)
      K_INF: pack_v = inf_v;
      K_NAN: begin pack_v = nan_v;  pack_f = 4'b1000; end
      K_OVF: begin pack_v = inf_v;  pack_f = 4'b0101; end
      K_UNF: begin pack_v = zero_v; pack_f = 4'b0011; end
      default: begin
        if (rnd_q.e == 10'd0 && FTZ) begin
          pack_v = zero_v;
          pack_f = 4'b0011;
        end else if (rnd_q.e >= emax) begin
          pack_v = inf_v;
          pack_f = 4'b0101;
        end else begin
          pack_v = norm_v;
          pack_f = {3'b000, rnd_q.inexact};
        end
      end
    endcase
    result_d    = result_q;
    out_flags_d = out_flags_q;
    if (!stall) begin
      result_d    = vld_pipe_q[PIPE_STAGES-1] ? pack_v : 32'd0;
      out_flags_d = vld_pipe_q[PIPE_STAGES-1] ? pack_f : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      req_q       <= '0;
      norm_q      <= '0;
      rnd_q       <= '0;
      result_q    <= '0;
      out_flags_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      req_q       <= req_d;
      norm_q      <= norm_d;
      rnd_q       <= rnd_d;
      result_q    <= result_d;
      out_flags_q <= out_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Bench for fp_mul_round_pack: directed vectors, latency, backpressure,
// mid-stream reset and a random stream scored against an arithmetic model.
`timescale 1ns/1ps
module tb_fp_mul_round_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] MANT = '0;
  logic [8:0]  EXP = '0;
  logic        SIGN = 1'b0;
  logic [4:0]  FLAGS = '0;
  logic        MODE_FP = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [47:0] mant;
    logic [8:0]  exp;
    logic        sign;
    logic [4:0]  flags;
    logic        mode;
  } bundle_t;

  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  bundle_t     idle_b;

  logic        s_ov = 1'b0, s_ir = 1'b1, s_or = 1'b1, acc = 1'b0;
  logic [31:0] s_res = '0, p_res = '0;
  logic [3:0]  s_fl = '0, p_fl = '0;
  logic        p_stall = 1'b0;

  always #5 clk = ~clk;

  fp_mul_round_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .MANT(MANT), .EXP(EXP), .SIGN(SIGN), .FLAGS(FLAGS), .MODE_FP(MODE_FP),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_flags(out_flags)
  );

  // Reference: round by comparing the discarded remainder against one half ulp.
  function automatic logic [35:0] model(input bundle_t b);
    int fb, emax, e, shift;
    longint unsigned q, rem, half;
    logic inex;
    logic [31:0] inf_v, zero_v, nan_v;
    fb     = b.mode ? 23 : 10;
    emax   = b.mode ? 255 : 31;
    inf_v  = b.mode ? {b.sign, 31'h7F800000} : {16'h0, b.sign, 15'h7C00};
    zero_v = b.mode ? {b.sign, 31'h0} : {16'h0, b.sign, 15'h0};
    nan_v  = b.mode ? 32'h7FC00000 : 32'h00007E00;
    if (b.flags == 5'b11111) return {4'b0000, inf_v};
    if (b.flags == 5'b00010) return {4'b0101, inf_v};
    if (b.flags == 5'b00011 || b.flags == 5'b10000) return {4'b0011, zero_v};
    if (b.flags != 5'b00000) return {4'b1000, nan_v};
    e     = int'(b.exp) + (b.mant[47] ? 1 : 0);
    shift = (b.mant[47] ? 47 : 46) - fb;
    q     = longint'(b.mant) >> shift;
    rem   = longint'(b.mant) & ((64'd1 << shift) - 1);
    half  = 64'd1 << (shift - 1);
    inex  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << (fb + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e == 0) return {4'b0011, zero_v};
    if (e >= emax) return {4'b0101, inf_v};
    if (b.mode) return {3'b000, inex, b.sign, 8'(e), 23'(q)};
    return {3'b000, inex, 16'h0, b.sign, 5'(e), 10'(q)};
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int r;
    b.mant = {16'($urandom), $urandom};
    if (!b.mant[47]) b.mant[46] = 1'b1;
    b.mode = 1'($urandom_range(0, 1));
    b.sign = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    b.flags = (r < 7) ? 5'd0 : 5'($urandom);
    case ($urandom_range(0, 3))
      0: b.exp = 9'($urandom);
      1: b.exp = 9'($urandom_range(0, 2));
      2: b.exp = b.mode ? 9'($urandom_range(252, 256)) : 9'($urandom_range(28, 32));
      default: b.exp = b.mode ? 9'($urandom_range(100, 150)) : 9'($urandom_range(8, 22));
    endcase
    return b;
  endfunction

  // One clock: drive at negedge, then record handshakes seen at the next posedge.
  task automatic cycle(input logic rst, input logic iv, input bundle_t b, input logic ordy);
    @(negedge clk);
    p_stall = s_ov && !s_or;
    p_res   = s_res;
    p_fl    = s_fl;
    rst_n = rst; in_valid = iv; out_ready = ordy;
    MANT = b.mant; EXP = b.exp; SIGN = b.sign; FLAGS = b.flags; MODE_FP = b.mode;
    #1;
    s_ov = out_valid; s_ir = in_ready; s_res = result; s_fl = out_flags; s_or = out_ready;
    acc = in_valid && in_ready && rst_n;
    if (acc) exp_q.push_back(model(b));
    if (out_valid && out_ready && rst_n) got_q.push_back({out_flags, result});
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && got_q.size() < exp_q.size(); k++) cycle(1, 0, idle_b, 1);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) cycle(0, 0, idle_b, 1);
    n_checks++;
    if (s_ov !== 1'b0 || s_res !== 32'h0 || s_fl !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b res=%h fl=%b, want 0/0/0", s_ov, s_res, s_fl);
    end
    cycle(1, 0, idle_b, 1);
    n_checks++;
    if (s_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", s_ir);
    end
  endtask

  task automatic test_latency();
    bundle_t b;
    b = '{mant: 48'h900000000000, exp: 9'd127, sign: 1'b0, flags: 5'd0, mode: 1'b1};
    exp_q.delete(); got_q.delete();
    cycle(1, 1, b, 1);
    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_accept: got %b want 1", acc);
    end
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 0, idle_b, 1);
      n_checks++;
      if (s_ov !== (k == 4)) begin
        n_fail++;
        $display("FAIL lat_valid_k%0d: got %b want %b", k, s_ov, (k == 4));
      end
    end
    n_checks++;
    if (s_res !== 32'h40100000 || s_fl !== 4'h0) begin
      n_fail++;
      $display("FAIL lat_result: got %h/%b want 40100000/0000", s_res, s_fl);
    end
    exp_q.delete(); got_q.delete();
  endtask

  localparam int ND = 14;
  logic [47:0] d_mant [ND] = '{48'h900000000000, 48'h900000000000, 48'h400000400000,
    48'h400000C00000, 48'hFFFFFFFFFFFF, 48'h800000000000, 48'h900000000000, 48'h900000000000,
    48'h900000000000, 48'h800000000000, 48'h900000000000, 48'h400000000000, 48'h900000000000,
    48'h400000000000};
  logic [8:0]  d_exp  [ND] = '{9'd127, 9'd15, 9'd127, 9'd127, 9'd127, 9'd254, 9'd127, 9'd127,
    9'd127, 9'd30, 9'd15, 9'd0, 9'd127, 9'd254};
  logic        d_sign [ND] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0};
  logic [4:0]  d_flg  [ND] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b11111, 5'b00001,
    5'b00011, 5'd0, 5'b00101, 5'd0, 5'b10000, 5'd0};
  logic        d_mode [ND] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
  logic [31:0] d_res  [ND] = '{32'h40100000, 32'h00004080, 32'h3F800000, 32'h3F800002,
    32'h40800000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h0000FC00,
    32'h00007E00, 32'h00008000, 32'h00000000, 32'h7F000000};
  logic [3:0]  d_fl   [ND] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0000,
    4'b1000, 4'b0011, 4'b0101, 4'b1000, 4'b0011, 4'b0011, 4'b0000};

  task automatic test_directed();
    bundle_t b;
    for (int i = 0; i < ND; i++) begin
      exp_q.delete(); got_q.delete();
      b = '{mant: d_mant[i], exp: d_exp[i], sign: d_sign[i], flags: d_flg[i], mode: d_mode[i]};
      cycle(1, 1, b, 1);
      drain();
      n_checks++;
      if (got_q.size() != 1) begin
        n_fail++;
        $display("FAIL dir%0d_count: got %0d results want 1", i, got_q.size());
      end else if (got_q[0] !== {d_fl[i], d_res[i]}) begin
        n_fail++;
        $display("FAIL dir%0d: got %h/%b want %h/%b", i, got_q[0][31:0], got_q[0][35:32],
                 d_res[i], d_fl[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    bundle_t bv[6];
    int idx;
    logic saw_low;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 6; i++) begin
      bv[i] = rand_bundle();
      bv[i].flags = 5'd0;
      bv[i].exp = bv[i].mode ? 9'(100 + i) : 9'(10 + i);
    end
    idx = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
      cycle(1, idx < 6, bv[idx < 6 ? idx : 0], !(c >= 4 && c <= 7));
      if (acc) idx++;
      n_checks++;
      if (s_ir !== !(s_ov && !s_or)) begin
        n_fail++;
        $display("FAIL bp_in_ready_c%0d: got %b want %b", c, s_ir, !(s_ov && !s_or));
      end
      if (!s_ir) saw_low = 1'b1;
      if (p_stall) begin
        n_checks++;
        if (s_ov !== 1'b1 || s_res !== p_res || s_fl !== p_fl) begin
          n_fail++;
          $display("FAIL bp_hold_c%0d: got %b/%h/%b want 1/%h/%b", c, s_ov, s_res, s_fl, p_res, p_fl);
        end
      end
    end
    n_checks++;
    if (saw_low !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_in_ready_low: got %b want 1", saw_low);
    end
    n_checks++;
    if (got_q.size() != 6 || exp_q.size() != 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d/%0d want 6", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_order%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    int stale;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 3; i++) cycle(1, 1, rand_bundle(), 1);
    cycle(0, 0, idle_b, 1);
    exp_q.delete();
    cycle(1, 0, idle_b, 1);
    n_checks++;
    if (s_ov !== 1'b0 || s_res !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_state: got ov=%b res=%h want 0/0", s_ov, s_res);
    end
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(1, 0, idle_b, 1);
      if (s_ov) stale++;
    end
    n_checks++;
    if (stale != 0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_stale: got %0d valid cycles want 0", stale);
    end
    for (int i = 0; i < 4; i++) cycle(1, 1, rand_bundle(), 1);
    drain();
    n_checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d/%0d want 4", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_res%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    int sent;
    exp_q.delete(); got_q.delete();
    sent = 0;
    for (int c = 0; c < 2000 && sent < 300; c++) begin
      cycle(1, $urandom_range(0, 9) < 8, rand_bundle(), $urandom_range(0, 9) < 7);
      if (acc) sent++;
      if (p_stall) begin
        n_checks++;
        if (s_res !== p_res || s_fl !== p_fl) begin
          n_fail++;
          $display("FAIL rnd_hold_c%0d: got %h/%b want %h/%b", c, s_res, s_fl, p_res, p_fl);
        end
      end
    end
    drain();
    n_checks++;
    if (got_q.size() != exp_q.size() || sent != 300) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d want %0d (sent %0d)", got_q.size(), exp_q.size(), sent);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rnd_res%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    idle_b = '{mant: 48'h0, exp: 9'h0, sign: 1'b0, flags: 5'h0, mode: 1'b0};
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
